// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: op encodings,
// default latencies and the control-state type.
package muldiv_unit_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  function automatic logic is_mult_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_long_op(input logic [MD_OP_W-1:0] op);
    return is_mult_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the md unit.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic               start;
  logic [MD_OP_W-1:0] op;
  logic [31:0]        a;
  logic [31:0]        b;
  logic               flush;
  logic               busy;
  logic               pending;
  logic [31:0]        hi;
  logic [31:0]        lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, pending, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, pending, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_md_divider.sv
// Combinational 32-bit signed/unsigned divider: quotient truncates toward
// zero, remainder takes the sign of the dividend.
module md_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;

  // Magnitude division keeps 0x80000000 / -1 well defined: |0x80000000| is
  // representable unsigned, and negating the quotient wraps back to 0x80000000.
  always_comb begin
    neg_a       = is_signed & dividend[31];
    neg_b       = is_signed & divisor[31];
    mag_a       = neg_a ? (32'd0 - dividend) : dividend;
    mag_b       = neg_b ? (32'd0 - divisor) : divisor;
    div_by_zero = (divisor == 32'd0);
    mag_q       = '0;
    mag_r       = '0;
    if (!div_by_zero) begin
      mag_q = mag_a / mag_b;
      mag_r = mag_a % mag_b;
    end
    quotient  = (neg_a ^ neg_b) ? (32'd0 - mag_q) : mag_q;
    remainder = neg_a ? (32'd0 - mag_r) : mag_r;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with architectural HI/LO. Long ops run for a fixed
// cycle count on latched operands; mthi/mtlo write in a single cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  md_state_e          state, state_next;
  logic [CNT_W-1:0]   counter, counter_next;
  logic [MD_OP_W-1:0] op_q, op_next;
  logic [31:0]        a_q, a_next;
  logic [31:0]        b_q, b_next;
  logic [31:0]        hi_q, hi_next;
  logic [31:0]        lo_q, lo_next;

  logic               busy;
  logic               mult_signed;
  logic [63:0]        mult_a;
  logic [63:0]        mult_b;
  logic [63:0]        product;
  logic               div_signed;
  logic [31:0]        quot;
  logic [31:0]        rem;
  logic               div_zero;

  // Sign-extending only for MULT lets one 64x64 multiplier (low half) serve both flavours.
  assign mult_signed = (op_q == MD_MULT);
  assign mult_a      = {{32{mult_signed & a_q[31]}}, a_q};
  assign mult_b      = {{32{mult_signed & b_q[31]}}, b_q};
  assign product     = mult_a * mult_b;
  assign div_signed  = (op_q == MD_DIV);

  md_divider u_div (
    .dividend    (a_q),
    .divisor     (b_q),
    .is_signed   (div_signed),
    .quotient    (quot),
    .remainder   (rem),
    .div_by_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      counter <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      op_q    <= op_next;
      a_q     <= a_next;
      b_q     <= b_next;
      hi_q    <= hi_next;
      lo_q    <= lo_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    op_next      = op_q;
    a_next       = a_q;
    b_next       = b_q;
    hi_next      = hi_q;
    lo_next      = lo_q;
    unique case (state)
      MD_IDLE: begin
        if (md.start && !md.flush) begin
          case (md.op)
            MD_MTHI: hi_next = md.a;
            MD_MTLO: lo_next = md.a;
            MD_MULT, MD_MULTU: begin
              state_next   = MD_BUSY;
              counter_next = CNT_W'(MULT_CYCLES - 1);
              op_next      = md.op;
              a_next       = md.a;
              b_next       = md.b;
            end
            MD_DIV, MD_DIVU: begin
              state_next   = MD_BUSY;
              counter_next = CNT_W'(DIV_CYCLES - 1);
              op_next      = md.op;
              a_next       = md.a;
              b_next       = md.b;
            end
            default: ;
          endcase
        end
      end
      MD_BUSY: begin
        if (counter != '0) begin
          counter_next = counter - CNT_W'(1);
        end else begin
          state_next = MD_IDLE;
          if (is_mult_op(op_q)) begin
            hi_next = product[63:32];
            lo_next = product[31:0];
          end else if (!div_zero) begin
            hi_next = rem;
            lo_next = quot;
          end
        end
      end
      default: state_next = MD_IDLE;
    endcase
  end

  assign busy       = (state == MD_BUSY);
  assign md.busy    = busy;
  assign md.pending = busy | (md.start & is_long_op(md.op) & ~md.flush);
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random traffic
// compared every cycle against a remaining-cycles behavioural model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic check_en = 1'b0;

  logic [31:0] m_hi, m_lo;
  int          m_left;
  logic [64:0] m_res;

  muldiv_unit_if md_if ();

  muldiv_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md_if)
  );

  always #5 clk = ~clk;

  // Reference result {div_by_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] mdResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib, iq, ir;
    longint      sp;
    logic [63:0] up;
    ia = a;
    ib = b;
    mdResult = '0;
    case (op)
      3'd0: begin
        sp = longint'(ia) * longint'(ib);
        mdResult = {1'b0, sp};
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        mdResult = {1'b0, up};
      end
      3'd2: begin
        if (b == 32'd0) mdResult = {1'b1, 64'd0};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) mdResult = {1'b0, 32'd0, 32'h8000_0000};
        else begin
          iq = ia / ib;
          ir = ia % ib;
          mdResult = {1'b0, ir, iq};
        end
      end
      3'd3: begin
        if (b == 32'd0) mdResult = {1'b1, 64'd0};
        else mdResult = {1'b0, a % b, a / b};
      end
      default: mdResult = '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hi = '0;
      m_lo = '0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && !m_res[64]) begin
        m_hi = m_res[63:32];
        m_lo = m_res[31:0];
      end
    end else if (md_if.start && !md_if.flush) begin
      case (md_if.op)
        3'd4: m_hi = md_if.a;
        3'd5: m_lo = md_if.a;
        3'd0, 3'd1: begin
          m_res = mdResult(md_if.op, md_if.a, md_if.b);
          m_left = NM;
        end
        3'd2, 3'd3: begin
          m_res = mdResult(md_if.op, md_if.a, md_if.b);
          m_left = ND;
        end
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cycle busy", 32'(md_if.busy), 32'(m_left > 0));
      checkOutput("cycle pending", 32'(md_if.pending),
                  32'((m_left > 0) || (md_if.start && md_if.op < 3'd4 && !md_if.flush)));
      checkOutput("cycle hi", md_if.hi, m_hi);
      checkOutput("cycle lo", md_if.lo, m_lo);
    end
  end

  task automatic applyStimulus(input logic start, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic flush);
    md_if.start = start;
    md_if.op    = op;
    md_if.a     = a;
    md_if.b     = b;
    md_if.flush = flush;
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (md_if.busy && n < 100) begin
      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      n++;
    end
    if (n >= 100) begin
      failures++;
      $display("[TB] FAIL busy timeout actual=stuck expected=idle");
    end
  endtask

  task automatic pinResult(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    checkOutput({name, " dut hi"}, md_if.hi, exp_hi);
    checkOutput({name, " dut lo"}, md_if.lo, exp_lo);
    checkOutput({name, " model hi"}, m_hi, exp_hi);
    checkOutput({name, " model lo"}, m_lo, exp_lo);
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    applyStimulus(1'b1, op, a, b, 1'b0);
    waitIdle(n);
    checkOutput({name, " busy cycles"}, 32'(n), 32'(exp_cycles));
    pinResult(name, exp_hi, exp_lo);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    rst_n = 1'b0;
    md_if.start = 1'b0;
    md_if.op    = '0;
    md_if.a     = '0;
    md_if.b     = '0;
    md_if.flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check_en = 1'b1;
    checkOutput("reset busy", 32'(md_if.busy), 32'd0);
    pinResult("reset", 32'd0, 32'd0);
    rst_n = 1'b1;

    runOp("mult -3*5", MD_MULT, 32'hFFFF_FFFD, 32'd5, NM, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runOp("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, NM, 32'h0000_0001, 32'hFFFF_FFFE);
    runOp("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    applyStimulus(1'b1, MD_MTHI, 32'h11, 32'd0, 1'b0);
    applyStimulus(1'b1, MD_MTLO, 32'h22, 32'd0, 1'b0);
    runOp("divu by zero", MD_DIVU, 32'd100, 32'd0, ND, 32'h11, 32'h22);

    applyStimulus(1'b1, MD_MTHI, 32'h1234, 32'd0, 1'b0);
    checkOutput("mthi busy", 32'(md_if.busy), 32'd0);
    pinResult("mthi", 32'h1234, 32'h22);

    applyStimulus(1'b1, MD_MULT, 32'd2, 32'd3, 1'b0);
    applyStimulus(1'b1, MD_MTLO, 32'h99, 32'd0, 1'b0);
    applyStimulus(1'b1, MD_MULT, 32'd4, 32'd5, 1'b0);
    waitIdle(n);
    checkOutput("busy-start busy cycles", 32'(n + 2), 32'(NM));
    pinResult("busy-start ignored", 32'd0, 32'd6);

    applyStimulus(1'b1, MD_DIV, 32'd50, 32'd7, 1'b1);
    checkOutput("start+flush busy", 32'(md_if.busy), 32'd0);
    pinResult("start+flush", 32'd0, 32'd6);

    applyStimulus(1'b1, MD_MULT, 32'd7, 32'd9, 1'b0);
    applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b1);
    waitIdle(n);
    checkOutput("flush mid busy cycles", 32'(n + 1), 32'(NM));
    pinResult("flush mid mult", 32'd0, 32'd63);

    runOp("div overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ND, 32'd0, 32'h8000_0000);

    applyStimulus(1'b1, MD_DIV, 32'd1000, 32'd3, 1'b0);
    applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b1;
    checkOutput("mid-div reset busy", 32'(md_if.busy), 32'd0);
    pinResult("mid-div reset", 32'd0, 32'd0);
    runOp("mult 6*7", MD_MULT, 32'd6, 32'd7, NM, 32'd0, 32'd42);

    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pickOperand(), pickOperand(),
                    $urandom_range(0, 7) == 0);
    end
    rst_n = 1'b1;
    waitIdle(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- EX-stage multiply/divide unit with architectural HI/LO registers for the P7 MIPS pipeline.
- Executes mult/multu/div/divu as multi-cycle operations and mthi/mtlo as single-cycle writes.
- Supplies HI/LO to the mfhi/mflo path, whose results the forwarding logic routes from EX/MEM.
- Exposes busy/pending so the hazard unit can stall dependent md instructions.

Parameters:
- MULT_CYCLES, 5, cycles busy is held high for mult/multu (>=1).
- DIV_CYCLES, 10, cycles busy is held high for div/divu (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  md instruction valid in EX this cycle.
- op  in  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- flush  in  1  exception/interrupt kills the EX instruction this cycle.
- busy  out  1  operation in progress.
- pending  out  1  busy OR (start AND op is mult/div AND NOT flush); drives the hazard-unit stall.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: when rst_n=0 at a rising edge, busy=0, counter=0, hi=0, lo=0, and any in-flight operation is discarded. Reset overrides every other input.
- Accept condition: start && !flush && !busy. Start while busy is ignored; the hazard unit guarantees this does not happen, but the unit must still ignore it. Start together with flush is ignored: no state change.
- MTHI/MTLO accepted at edge E: hi (or lo) <= a at E. busy does not rise. The new value is visible in the cycle after E.
- MULT/MULTU/DIV/DIVU accepted at edge E0:
  - latch a, b and op;
  - counter <= N-1 (N = MULT_CYCLES or DIV_CYCLES);
  - busy <= 1.
- Each subsequent edge with busy=1: if counter != 0, counter decrements. If counter == 0, {hi,lo} is written with the result and busy <= 0.
- busy is therefore high for exactly N cycles. The result is visible in the first cycle busy is low.
- hi/lo hold their old values throughout busy.
- flush while busy does not cancel the operation; the instruction has already committed past EX.
- Arithmetic:
  - MULT: 64-bit signed product. MULTU: 64-bit unsigned product. {hi,lo} = product.
  - DIV: lo = quotient truncated toward zero; hi = remainder, sign of the dividend.
  - DIVU: unsigned lo = a/b, hi = a%b.
  - Divide by zero (b=0): hi and lo are left unchanged; busy timing is unaffected.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Result computation may be combinational on the latched operands or iterative (restoring divider, one bit per cycle). Externally visible timing must match the N-cycle rule either way. An iterative divider requires DIV_CYCLES >= 33, or it must compute combinationally.
- Invalid op codes with start: ignored.

Decomposition:
- Shared package (with the other control constants): op encodings MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5; default cycle counts.
- Optional sub-module md_divider: 32-bit signed/unsigned divider returning quotient and remainder, with divide-by-zero flag. Multiply stays inline.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, start at edge E0 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo unchanged while busy.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE. DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles; hi=0x11, lo=0x22 afterwards.
- MTHI a=0x1234 while idle -> hi=0x1234 next cycle, busy stays 0. MTLO during busy -> ignored. Second MULT start during busy -> ignored, result from the first.
- start+flush same cycle with DIV -> busy stays 0, pending=0, hi/lo unchanged. flush mid-MULT -> MULT completes normally.
- rst_n=0 at cycle 3 of a DIV -> next cycle busy=0, hi=0, lo=0; the following MULT 6*7 gives lo=42, hi=0.
